// File: rtl/dino_game_ctrl.sv
// Dino matrix game sequencer: game FSM, frame-tick divider, rock scroll timing,
// jump profile, score keeping and display blanking.
module dino_game_ctrl #(
  parameter int unsigned TICK_DIV      = 2500000,
  parameter int unsigned SCROLL_FRAMES = 4,
  parameter int unsigned JUMP_FRAMES   = 6,
  parameter int unsigned HIT_FRAMES    = 8,
  parameter int unsigned SPEEDUP_SCORE = 16
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       jump_btn,
  input  logic       collision,
  output logic       det_clear,
  output logic       frame_tick,
  output logic       scroll_en,
  output logic       jump_active,
  output logic [1:0] dino_height,
  output logic [9:0] score,
  output logic       display_blank,
  output logic       game_over,
  output logic [1:0] state
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned SCR_W = $clog2(SCROLL_FRAMES + 1);
  localparam int unsigned JMP_W = $clog2(JUMP_FRAMES + 1);
  localparam int unsigned HIT_W = $clog2(HIT_FRAMES + 2);
  localparam int unsigned SPD_W = $clog2(SPEEDUP_SCORE + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [SCR_W-1:0] PER_INIT  = SCR_W'(SCROLL_FRAMES);
  localparam logic [SCR_W-1:0] SCR_ONE   = SCR_W'(1);
  localparam logic [JMP_W-1:0] JMP_INIT  = JMP_W'(JUMP_FRAMES);
  localparam logic [JMP_W-1:0] JMP_ONE   = JMP_W'(1);
  localparam logic [HIT_W-1:0] HIT_LAST  = HIT_W'(HIT_FRAMES);
  localparam logic [HIT_W-1:0] HIT_ONE   = HIT_W'(1);
  localparam logic [SPD_W-1:0] SPD_LAST  = SPD_W'(SPEEDUP_SCORE - 1);
  localparam logic [SPD_W-1:0] SPD_ONE   = SPD_W'(1);
  localparam logic [9:0]       SCORE_MAX = 10'd999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t           cur, nxt;
  logic [DIV_W-1:0] div_q;
  logic [SCR_W-1:0] scnt, scnt_n, per, per_n;
  logic [SPD_W-1:0] spd, spd_n;
  logic [JMP_W-1:0] jcnt, jcnt_n;
  logic [HIT_W-1:0] hcnt, hcnt_n;
  logic             det_n, scroll_n, jact_n, blank_n, over_n;
  logic [1:0]       hgt_n;
  logic [9:0]       score_n;

  assign state = cur;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      cur           <= IDLE;
      div_q         <= '0;
      frame_tick    <= 1'b0;
      scnt          <= '0;
      per           <= '0;
      spd           <= '0;
      jcnt          <= '0;
      hcnt          <= '0;
      det_clear     <= 1'b0;
      scroll_en     <= 1'b0;
      jump_active   <= 1'b0;
      dino_height   <= '0;
      score         <= '0;
      display_blank <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      cur           <= nxt;
      div_q         <= (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
      frame_tick    <= (div_q == DIV_LAST);
      scnt          <= scnt_n;
      per           <= per_n;
      spd           <= spd_n;
      jcnt          <= jcnt_n;
      hcnt          <= hcnt_n;
      det_clear     <= det_n;
      scroll_en     <= scroll_n;
      jump_active   <= jact_n;
      dino_height   <= hgt_n;
      score         <= score_n;
      display_blank <= blank_n;
      game_over     <= over_n;
    end
  end

  always_comb begin
    nxt      = cur;
    det_n    = 1'b0;
    scroll_n = 1'b0;
    scnt_n   = scnt;
    per_n    = per;
    spd_n    = spd;
    jcnt_n   = jcnt;
    jact_n   = jump_active;
    hgt_n    = dino_height;
    score_n  = score;
    hcnt_n   = hcnt;
    blank_n  = display_blank;
    case (cur)
      IDLE, OVER: begin
        if (start_btn) begin
          nxt     = RUN;
          det_n   = 1'b1;
          scnt_n  = '0;
          per_n   = PER_INIT;
          spd_n   = '0;
          jcnt_n  = '0;
          jact_n  = 1'b0;
          hgt_n   = '0;
          score_n = '0;
          blank_n = 1'b0;
          hcnt_n  = '0;
        end
      end
      RUN: begin
        // Collision wins over a due scroll; the whole RUN update is skipped.
        if (collision && !det_clear) begin
          nxt     = HIT;
          hcnt_n  = '0;
          blank_n = 1'b0;
        end else begin
          if (frame_tick) begin
            if (scnt == per - SCR_ONE) begin
              scnt_n   = '0;
              scroll_n = 1'b1;
              // spd tracks points since the last speedup, replacing a modulo on score.
              if (score != SCORE_MAX) begin
                score_n = score + 10'd1;
                if (spd == SPD_LAST) begin
                  spd_n = '0;
                  if (per != SCR_ONE) per_n = per - SCR_ONE;
                end else begin
                  spd_n = spd + SPD_ONE;
                end
              end
            end else begin
              scnt_n = scnt + SCR_ONE;
            end
          end
          if (!jump_active) begin
            if (jump_btn) begin
              jact_n = 1'b1;
              jcnt_n = JMP_INIT;
            end
          end else if (frame_tick) begin
            jcnt_n = jcnt - JMP_ONE;
            jact_n = (jcnt_n != '0);
          end
          if (!jact_n)                                 hgt_n = 2'd0;
          else if (jcnt_n == JMP_INIT || jcnt_n == JMP_ONE) hgt_n = 2'd1;
          else                                         hgt_n = 2'd2;
        end
      end
      HIT: begin
        if (hcnt == HIT_LAST) begin
          nxt     = OVER;
          blank_n = 1'b1;
        end else if (frame_tick) begin
          hcnt_n  = hcnt + HIT_ONE;
          blank_n = !display_blank;
        end
      end
      default: nxt = IDLE;
    endcase
    over_n = (nxt == OVER);
  end

endmodule
